// File: rtl/pbuf2ddr_pkg.sv
// Shared data widths and the bit-width helper for the pbuf read-back path.
package pbuf2ddr_pkg;

  localparam int DATA_W = 16;
  localparam int BATCH  = 4;
  localparam int DDR_W  = 64;

  function automatic int bw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pbuf2ddr_if.sv
// Bundles the pbuf read port and the DDR valid/ready stream of pbuf2ddr.
interface pbuf2ddr_if
  import pbuf2ddr_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 5,
  parameter int DDR_WIDTH = DDR_W
) ();

  logic                 pbuf_rd_en;
  logic [SEL_W-1:0]     pbuf_rd_sel;
  logic [ADDR_W-1:0]    pbuf_rd_addr;
  logic [DDR_WIDTH-1:0] pbuf_rd_data;
  logic [DDR_WIDTH-1:0] ddr_data;
  logic                 ddr_valid;
  logic                 ddr_ready;

  modport master (
    output pbuf_rd_en, pbuf_rd_sel, pbuf_rd_addr, ddr_data, ddr_valid,
    input  pbuf_rd_data, ddr_ready
  );

  modport slave (
    input  pbuf_rd_en, pbuf_rd_sel, pbuf_rd_addr, ddr_data, ddr_valid,
    output pbuf_rd_data, ddr_ready
  );

endinterface

// File: rtl/pbuf2ddr_sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data always shows the head entry.
module sync_fwft_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign empty   = (r_count == '0);
  assign full    = (r_count == CNT_W'(DEPTH));
  assign count   = r_count;
  assign rd_data = r_mem[r_rdPtr];
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
      if (w_rd) r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wrPtr] <= wr_data;
  end

  assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/pbuf2ddr.sv
// Streams the enabled PE parameter buffers out to DDR, PE ascending then address ascending.
module pbuf2ddr
  import pbuf2ddr_pkg::*;
#(
  parameter int BUF_DEPTH  = 256,
  parameter int ADDR_W     = bw(BUF_DEPTH),
  parameter int PE_NUM     = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_done,
  input  logic [7:0]        i_conf_trans_num,
  input  logic [PE_NUM-1:0] i_conf_mask,
  pbuf2ddr_if.master        bus
);

  localparam int SEL_W  = bw(PE_NUM);
  localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
  localparam int CMP_W  = (ADDR_W > 8) ? ADDR_W : 8;

  typedef enum logic [1:0] {IDLE, SCAN, READ, DRAIN} state_t;

  if (DDR_W != DATA_W * BATCH) begin : g_badDdrWidth
    $error("pbuf2ddr: DDR_W must equal DATA_W*BATCH");
  end
  if (FIFO_DEPTH < RD_LAT + 2) begin : g_badFifoDepth
    $error("pbuf2ddr: FIFO_DEPTH must be at least RD_LAT+2");
  end

  state_t                r_state;
  state_t                w_nextState;
  logic [SEL_W-1:0]      r_peIdx;
  logic [SEL_W-1:0]      w_nextPeIdx;
  logic [ADDR_W-1:0]     r_addr;
  logic [ADDR_W-1:0]     w_nextAddr;
  logic [PE_NUM-1:0]     r_mask;
  logic [7:0]            r_transNum;
  logic [CRED_W-1:0]     r_credits;
  logic [RD_LAT-1:0]     r_rdPipe;
  logic                  w_issue;
  logic                  w_ret;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_lastAddr;
  logic                  w_lastPe;
  logic [CRED_W-1:0]     w_count;
  logic [DDR_W-1:0]      w_head;

  assign w_lastAddr = (CMP_W'(r_addr) == CMP_W'(r_transNum));
  assign w_lastPe   = (r_peIdx == SEL_W'(PE_NUM - 1));
  assign w_ret      = r_rdPipe[RD_LAT-1];
  assign w_pop      = !w_empty && bus.ddr_ready;

  assign o_done            = (r_state == IDLE);
  assign bus.pbuf_rd_en    = w_issue;
  assign bus.pbuf_rd_sel   = r_peIdx;
  assign bus.pbuf_rd_addr  = r_addr;
  assign bus.ddr_valid     = !w_empty;
  assign bus.ddr_data      = w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_peIdx    <= '0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_transNum <= '0;
      r_credits  <= CRED_W'(FIFO_DEPTH);
      r_rdPipe   <= '0;
    end else begin
      r_state   <= w_nextState;
      r_peIdx   <= w_nextPeIdx;
      r_addr    <= w_nextAddr;
      r_credits <= r_credits - CRED_W'(w_issue) + CRED_W'(w_pop);
      r_rdPipe  <= (r_rdPipe << 1) | RD_LAT'(w_issue);
      if (r_state == IDLE && i_start) begin
        r_mask     <= i_conf_mask;
        r_transNum <= i_conf_trans_num;
      end
    end
  end

  // A read is only issued when a FIFO slot is already reserved for its return.
  always_comb begin
    w_nextState = r_state;
    w_nextPeIdx = r_peIdx;
    w_nextAddr  = r_addr;
    w_issue     = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextState = SCAN;
          w_nextPeIdx = '0;
          w_nextAddr  = '0;
        end
      end
      SCAN: begin
        if (r_mask[r_peIdx]) begin
          w_nextState = READ;
          w_nextAddr  = '0;
        end else if (w_lastPe) begin
          w_nextState = DRAIN;
        end else begin
          w_nextPeIdx = r_peIdx + SEL_W'(1);
        end
      end
      READ: begin
        if (r_credits != '0) begin
          w_issue    = 1'b1;
          w_nextAddr = r_addr + ADDR_W'(1);
          if (w_lastAddr) begin
            if (w_lastPe) begin
              w_nextState = DRAIN;
            end else begin
              w_nextState = SCAN;
              w_nextPeIdx = r_peIdx + SEL_W'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (w_empty && r_rdPipe == '0) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  sync_fwft_fifo #(
    .WIDTH (DDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_ret),
    .wr_data (bus.pbuf_rd_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .empty   (w_empty),
    .full    (w_full),
    .count   (w_count)
  );

  assert property (@(posedge clk) disable iff (rst) !(w_ret && w_full));
  assert property (@(posedge clk) disable iff (rst)
    int'(r_credits) + $countones(r_rdPipe) + int'(w_count) == FIFO_DEPTH);

endmodule

// File: tb/tb_pbuf2ddr.sv
// Self-checking bench for pbuf2ddr: table of transfers, random backpressure, reset and busy-start corners.
module tb_pbuf2ddr;
  import pbuf2ddr_pkg::*;

  localparam int PE_NUM     = 32;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 8;
  localparam int LIMIT      = 40000;

  typedef struct {
    logic [31:0] mask;
    logic [7:0]  tn;
    int          mode;
    int          expBeats;
    bit          burst;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        done;
  logic [7:0]  confTransNum;
  logic [31:0] confMask;

  pbuf2ddr_if #(.ADDR_W(8), .SEL_W(5), .DDR_WIDTH(DDR_W)) bus ();

  pbuf2ddr dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (start),
    .o_done           (done),
    .i_conf_trans_num (confTransNum),
    .i_conf_mask      (confMask),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int pe, input int a);
    return {8'(pe), 8'(a), 16'hC3A5, 8'(pe) ^ 8'h3C, 8'(a) ^ 8'h96, 8'(pe + a), 8'(a * 3 + pe)};
  endfunction

  // Buffer model: data for a read shows up RD_LAT cycles later, garbage otherwise.
  logic [63:0] pipeA, pipeB;
  always @(posedge clk) begin
    pipeA <= bus.pbuf_rd_en ? pat(int'(bus.pbuf_rd_sel), int'(bus.pbuf_rd_addr))
                            : {$urandom, $urandom};
    pipeB <= pipeA;
  end
  assign bus.pbuf_rd_data = pipeB;

  int          assertCount = 0;
  int          failCount   = 0;
  int          cycleNo     = 0;
  int          readyMode   = 0;
  int          issueCount, beatCount, inflight;
  int          firstRd, firstValid, firstHs, lastHs;
  bit          prevStall;
  logic [63:0] prevData;
  logic [63:0] expQ[$];
  logic [12:0] issueQ[$];
  vec_t        vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  task automatic buildModel(input logic [31:0] mask, input logic [7:0] tn);
    for (int pe = 0; pe < PE_NUM; pe++) begin
      if (mask[pe]) begin
        for (int a = 0; a <= int'(tn); a++) begin
          expQ.push_back(pat(pe, a));
          issueQ.push_back({5'(pe), 8'(a)});
        end
      end
    end
  endtask

  task automatic monitor();
    if (prevStall) begin
      checkOutput("holdValid", 64'(bus.ddr_valid), 64'd1);
      checkOutput("holdData", bus.ddr_data, prevData);
    end
    prevStall = bus.ddr_valid && !bus.ddr_ready;
    prevData  = bus.ddr_data;
    if (bus.ddr_valid && firstValid < 0) firstValid = cycleNo;
    if (bus.pbuf_rd_en) begin
      if (firstRd < 0) firstRd = cycleNo;
      issueCount++;
      inflight++;
      if (issueQ.size() == 0) checkOutput("unexpectedRead", 64'(bus.pbuf_rd_en), 64'd0);
      else checkOutput("readSelAddr", 64'({bus.pbuf_rd_sel, bus.pbuf_rd_addr}), 64'(issueQ.pop_front()));
      checkOutput("creditBound", 64'(inflight > FIFO_DEPTH), 64'd0);
    end
    if (bus.ddr_valid && bus.ddr_ready) begin
      inflight--;
      beatCount++;
      if (firstHs < 0) firstHs = cycleNo;
      lastHs = cycleNo;
      if (expQ.size() == 0) checkOutput("extraBeat", 64'(bus.ddr_valid), 64'd0);
      else checkOutput("beatData", bus.ddr_data, expQ.pop_front());
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cycleNo++;
    if (readyMode == 0) bus.ddr_ready = 1'b1;
    else if (readyMode == 1) bus.ddr_ready = 1'($urandom_range(0, 1));
    else bus.ddr_ready = 1'b0;
  endtask

  task automatic clearStats();
    issueCount = 0;
    beatCount  = 0;
    firstRd    = -1;
    firstValid = -1;
    firstHs    = -1;
    lastHs     = -1;
  endtask

  task automatic applyStimulus(input logic [31:0] mask, input logic [7:0] tn, input bit addModel);
    confMask     = mask;
    confTransNum = tn;
    if (addModel) buildModel(mask, tn);
    start = 1'b1;
    stepCycle();
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!done && cycles < LIMIT) begin
      stepCycle();
      cycles++;
    end
    if (!done) checkOutput("doneTimeout", 64'(done), 64'd1);
  endtask

  task automatic runVector(input vec_t v);
    int cycles;
    clearStats();
    readyMode = v.mode;
    applyStimulus(v.mask, v.tn, 1'b1);
    checkOutput("doneLowAfterStart", 64'(done), 64'd0);
    if (v.mode == 2) begin
      repeat (18) stepCycle();
      checkOutput("stallIssueCount", 64'(issueCount), 64'((v.expBeats < FIFO_DEPTH) ? v.expBeats : FIFO_DEPTH));
      readyMode     = 0;
      bus.ddr_ready = 1'b1;
    end
    waitDone(cycles);
    checkOutput("beatCount", 64'(beatCount), 64'(v.expBeats));
    checkOutput("leftoverBeats", 64'(expQ.size()), 64'd0);
    if (v.expBeats > 0)
      checkOutput("firstBeatLatency", 64'(firstValid - firstRd), 64'(RD_LAT + 1));
    if (v.burst)
      checkOutput("burstSpan", 64'(lastHs - firstHs), 64'(v.expBeats - 1));
    expQ.delete();
    issueQ.delete();
    inflight  = 0;
    prevStall = 1'b0;
  endtask

  initial begin
    int   lowCycles;
    vec_t post;
    rst = 1'b1; start = 1'b0; confMask = '0; confTransNum = '0;
    bus.ddr_ready = 1'b1;
    inflight = 0; prevStall = 1'b0; prevData = '0;
    clearStats();

    vecs[0] = '{32'h0000_0001, 8'd3,   0, 4,    1'b1};
    vecs[1] = '{32'h8000_0005, 8'd1,   0, 6,    1'b0};
    vecs[2] = '{32'h0000_0001, 8'd15,  2, 16,   1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 8'd255, 1, 8192, 1'b0};
    vecs[4] = '{32'h0000_0F00, 8'd0,   0, 4,    1'b0};
    for (int i = 5; i < 8; i++) begin
      vecs[i].mask     = $urandom;
      vecs[i].tn       = 8'($urandom_range(0, 7));
      vecs[i].mode     = 1;
      vecs[i].expBeats = $countones(vecs[i].mask) * (int'(vecs[i].tn) + 1);
      vecs[i].burst    = 1'b0;
    end

    @(posedge clk);
    #1;
    repeat (3) stepCycle();
    checkOutput("resetDone", 64'(done), 64'd1);
    checkOutput("resetValid", 64'(bus.ddr_valid), 64'd0);
    checkOutput("resetRdEn", 64'(bus.pbuf_rd_en), 64'd0);
    checkOutput("resetRdSel", 64'(bus.pbuf_rd_sel), 64'd0);
    checkOutput("resetRdAddr", 64'(bus.pbuf_rd_addr), 64'd0);
    rst = 1'b0;
    stepCycle();

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d mask=%h tn=%0d mode=%0d", i, vecs[i].mask, vecs[i].tn, vecs[i].mode);
      runVector(vecs[i]);
    end

    // Empty mask, with a second start issued while the scan is still running.
    clearStats();
    readyMode = 0;
    applyStimulus(32'h0, 8'd4, 1'b1);
    lowCycles = 1;
    while (!done && lowCycles < LIMIT) begin
      if (lowCycles == 5) applyStimulus(32'h0000_0001, 8'd0, 1'b0);
      else stepCycle();
      lowCycles++;
    end
    checkOutput("maskZeroDone", 64'(done), 64'd1);
    checkOutput("maskZeroLowCycles", 64'(lowCycles <= PE_NUM + 2), 64'd1);
    repeat (20) stepCycle();
    checkOutput("maskZeroBeats", 64'(beatCount), 64'd0);
    checkOutput("busyStartIgnored", 64'(issueCount), 64'd0);

    // Reset in the middle of a long transfer, then a clean transfer.
    clearStats();
    readyMode = 1;
    applyStimulus(32'hFFFF_FFFF, 8'd255, 1'b1);
    repeat (50) stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    expQ.delete();
    issueQ.delete();
    inflight  = 0;
    prevStall = 1'b0;
    checkOutput("midResetValid", 64'(bus.ddr_valid), 64'd0);
    checkOutput("midResetDone", 64'(done), 64'd1);
    checkOutput("midResetRdEn", 64'(bus.pbuf_rd_en), 64'd0);
    readyMode = 0;
    repeat (4) stepCycle();
    checkOutput("postResetQuiet", 64'(bus.ddr_valid), 64'd0);
    post = '{32'h0000_0003, 8'd2, 0, 6, 1'b0};
    runVector(post);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
